// File: rtl/lane_loader_pkg.sv
// Shared types and helpers for the lane loader: FSM state encoding and the
// element-index to lane/slot split used on the write side.
package lane_loader_pkg;

    typedef enum logic {
        LOAD,
        FULL
    } ll_state_t;

    typedef struct packed {
        int unsigned lane;
        int unsigned slot;
    } ll_split_t;

    // Element k of a load goes to lane k mod lanes, slot k div lanes.
    function automatic ll_split_t ll_split(input int unsigned idx, input int unsigned lanes);
        ll_split_t r;
        r.lane = idx % lanes;
        r.slot = idx / lanes;
        return r;
    endfunction

endpackage

// File: rtl/lane_buffer.sv
// One lane of storage: DEPTH x DATA_W register array, single write port,
// asynchronous read port addressed by the replay pointer.
module lane_buffer
    import lane_loader_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned SLOT_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [SLOT_W-1:0] wr_slot,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [SLOT_W-1:0] rd_slot,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage: zeroed by reset only; later loads simply overwrite.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned s = 0; s < DEPTH; s++) begin
                mem[s] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_slot] <= wr_data;
        end
    end

    assign rd_data = mem[rd_slot];

endmodule

// File: rtl/lane_loader.sv
// Serial-to-lane loader: fills LANES lane buffers round-robin from a
// valid/ready byte stream, then replays one column per read request in
// rotate (reuse) or consume (free for next load) mode.
module lane_loader
    import lane_loader_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LANES  = 4,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clear,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    rd_req,
    input  logic                    rd_mode,
    output logic [LANES*DATA_W-1:0] rd_data,
    output logic                    rd_valid,
    output logic                    load_done,
    output logic                    full,
    output logic                    overflow
);

    localparam int unsigned TOTAL = LANES * DEPTH;
    localparam int unsigned CNT_W = $clog2(TOTAL);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    ll_state_t               state;
    logic [CNT_W-1:0]        wr_cnt;
    logic [PTR_W-1:0]        rd_ptr;
    logic                    load_accept;
    ll_split_t               split;
    logic [PTR_W-1:0]        wr_slot;
    logic [LANES-1:0]        wr_en;
    logic [DATA_W-1:0]       lane_out [LANES];
    logic [LANES*DATA_W-1:0] column;

    assign in_ready    = (state == LOAD);
    assign load_accept = (state == LOAD) && in_valid && !clear;

    // Decode the write counter into a target lane and slot.
    always_comb begin
        split   = ll_split(32'(wr_cnt), LANES);
        wr_slot = PTR_W'(split.slot);
        wr_en   = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            wr_en[i] = load_accept && (split.lane == i);
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        lane_buffer #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .SLOT_W (PTR_W)
        ) u_lane (
            .clk     (clk),
            .reset_n (reset_n),
            .wr_en   (wr_en[g]),
            .wr_slot (wr_slot),
            .wr_data (in_data),
            .rd_slot (rd_ptr),
            .rd_data (lane_out[g])
        );
        assign column[g*DATA_W +: DATA_W] = lane_out[g];
    end

    // Load/serve FSM with counters, sticky overflow and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= LOAD;
            wr_cnt    <= '0;
            rd_ptr    <= '0;
            full      <= 1'b0;
            overflow  <= 1'b0;
            load_done <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
        end else begin
            load_done <= 1'b0;
            rd_valid  <= 1'b0;
            if (clear) begin
                state    <= LOAD;
                wr_cnt   <= '0;
                rd_ptr   <= '0;
                full     <= 1'b0;
                overflow <= 1'b0;
            end else begin
                case (state)
                    LOAD: begin
                        if (in_valid) begin
                            if (wr_cnt == CNT_W'(TOTAL - 1)) begin
                                wr_cnt    <= '0;
                                state     <= FULL;
                                full      <= 1'b1;
                                load_done <= 1'b1;
                            end else begin
                                wr_cnt <= wr_cnt + 1'b1;
                            end
                        end
                    end
                    FULL: begin
                        if (in_valid) begin
                            overflow <= 1'b1;
                        end
                        if (rd_req) begin
                            rd_valid <= 1'b1;
                            rd_data  <= column;
                            if (rd_ptr == PTR_W'(DEPTH - 1)) begin
                                rd_ptr <= '0;
                                if (rd_mode) begin
                                    state <= LOAD;
                                    full  <= 1'b0;
                                end
                            end else begin
                                rd_ptr <= rd_ptr + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= LOAD;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lane_loader.sv
// Self-checking bench for lane_loader: directed scenarios plus randomized
// traffic, compared every cycle against an element-order reference model.
module tb_lane_loader;

    localparam int DATA_W = 8;
    localparam int LANES  = 4;
    localparam int DEPTH  = 8;
    localparam int TOTAL  = LANES * DEPTH;

    logic                    clk = 1'b0;
    logic                    reset_n = 1'b0;
    logic                    clear = 1'b0;
    logic [DATA_W-1:0]       in_data = '0;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic                    rd_req = 1'b0;
    logic                    rd_mode = 1'b0;
    logic [LANES*DATA_W-1:0] rd_data;
    logic                    rd_valid;
    logic                    load_done;
    logic                    full;
    logic                    overflow;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: elements kept in arrival order; column c lane i is element c*LANES+i.
    logic [DATA_W-1:0]       stored [TOTAL];
    bit                      m_full;
    int                      m_count;
    int                      m_ptr;
    bit                      m_ovf;
    bit                      m_rd_valid;
    bit                      m_load_done;
    logic [LANES*DATA_W-1:0] m_rd_data;

    lane_loader #(
        .DATA_W (DATA_W),
        .LANES  (LANES),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rd_req    (rd_req),
        .rd_mode   (rd_mode),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .load_done (load_done),
        .full      (full),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < TOTAL; k++) stored[k] = '0;
        m_full      = 0;
        m_count     = 0;
        m_ptr       = 0;
        m_ovf       = 0;
        m_rd_valid  = 0;
        m_load_done = 0;
        m_rd_data   = '0;
    endtask

    task automatic model_edge(input bit v, input logic [DATA_W-1:0] d, input bit r, input bit m, input bit c);
        m_rd_valid  = 0;
        m_load_done = 0;
        if (c) begin
            m_full  = 0;
            m_count = 0;
            m_ptr   = 0;
            m_ovf   = 0;
        end else if (!m_full) begin
            if (v) begin
                stored[m_count] = d;
                m_count++;
                if (m_count == TOTAL) begin
                    m_count     = 0;
                    m_full      = 1;
                    m_load_done = 1;
                end
            end
        end else begin
            if (v) m_ovf = 1;
            if (r) begin
                for (int i = 0; i < LANES; i++)
                    m_rd_data[i*DATA_W +: DATA_W] = stored[m_ptr*LANES + i];
                m_rd_valid = 1;
                if (m_ptr == DEPTH - 1) begin
                    m_ptr = 0;
                    if (m) m_full = 0;
                end else begin
                    m_ptr++;
                end
            end
        end
    endtask

    task automatic check_outputs(input string ctx);
        check({ctx, ".in_ready"},  64'(in_ready),  64'(!m_full));
        check({ctx, ".full"},      64'(full),      64'(m_full));
        check({ctx, ".load_done"}, 64'(load_done), 64'(m_load_done));
        check({ctx, ".rd_valid"},  64'(rd_valid),  64'(m_rd_valid));
        check({ctx, ".overflow"},  64'(overflow),  64'(m_ovf));
        check({ctx, ".rd_data"},   64'(rd_data),   64'(m_rd_data));
    endtask

    // One clock cycle: drive at negedge, model the edge, sample 1 time unit after.
    task automatic step(input string ctx, input bit v, input logic [DATA_W-1:0] d,
                        input bit r, input bit m, input bit c);
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        rd_req   = r;
        rd_mode  = m;
        clear    = c;
        @(posedge clk);
        model_edge(v, d, r, m, c);
        #1;
        check_outputs(ctx);
    endtask

    task automatic load_seq(input string ctx, input int base);
        for (int k = 0; k < TOTAL; k++) step(ctx, 1, DATA_W'(base + k), 0, 0, 0);
    endtask

    task automatic async_reset(input string ctx);
        @(negedge clk);
        #2;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        rd_req   = 1'b0;
        clear    = 1'b0;
        #1;
        model_reset();
        check_outputs(ctx);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #12;
        check_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Full load, load_done one cycle after the last byte.
        load_seq("load0", 8'h00);
        check("load_done_pulse", 64'(load_done), 64'd1);
        step("idle", 0, 0, 0, 0, 0);
        check("load_done_once", 64'(load_done), 64'd0);

        // Rotate: 9 reads wrap back to column 0.
        for (int n = 0; n < 9; n++) begin
            step("rotate", 0, 0, 1, 0, 0);
            if (n == 0) check("col0_const", 64'(rd_data), 64'h03020100);
            if (n == 7) check("col7_const", 64'(rd_data), 64'h1F1E1D1C);
            if (n == 8) check("col0_again", 64'(rd_data), 64'h03020100);
        end
        check("rotate_full", 64'(full), 64'd1);

        // Pointer now at 1: rotate back to 0, then consume 8 columns.
        for (int n = 0; n < 7; n++) step("rot_align", 0, 0, 1, 0, 0);
        for (int n = 0; n < 8; n++) step("consume", 0, 0, 1, 1, 0);
        check("consume_empty", 64'(in_ready), 64'd1);

        load_seq("load1", 8'h20);
        step("rd_reload", 0, 0, 1, 0, 0);
        check("reload_col0", 64'(rd_data), 64'h23222120);

        // Overflow while FULL, then clear.
        step("ovf", 1, 8'hAA, 0, 0, 0);
        step("ovf_hold", 0, 0, 0, 0, 0);
        for (int n = 0; n < 8; n++) step("ovf_rd", 0, 0, 1, 0, 0);
        step("clear", 0, 0, 1, 0, 1);
        check("clear_ovf", 64'(overflow), 64'd0);

        // Simultaneous write + read request during LOAD.
        for (int n = 0; n < 3; n++) step("simul", 1, DATA_W'(8'h50 + n), 1, 0, 0);

        // Reset mid-load after 10 bytes, then a fresh load.
        step("clear2", 0, 0, 0, 0, 1);
        for (int k = 0; k < 10; k++) step("partial", 1, DATA_W'(k), 0, 0, 0);
        async_reset("midreset");
        load_seq("load2", 8'h00);
        step("rd_after_rst", 0, 0, 1, 0, 0);
        check("rst_col0", 64'(rd_data), 64'h03020100);

        // Reset mid-read.
        step("rd_mid", 0, 0, 1, 1, 0);
        async_reset("rdreset");

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            step("rand",
                 bit'($urandom_range(0, 3) != 0),
                 DATA_W'($urandom),
                 bit'($urandom_range(0, 1)),
                 bit'($urandom_range(0, 1)),
                 bit'($urandom_range(0, 63) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lane_loader.md
# lane_loader

Parametrised serial-to-lane loader for the matrix datapath. It accepts a byte stream on a valid/ready handshake and distributes elements round-robin into LANES lane buffers of DEPTH entries each. Once the buffers are full it replays them one column per request, either rotating for reuse or consuming to free the buffers for the next load. It sits between the host input port and the processing-element array, which takes one element per lane per read.

## Interface
- DATA_W, 8: element width in bits
- LANES, 4: number of lanes (output channels); must be ≥2
- DEPTH, 8: entries per lane; must be ≥2
- clk  in  1  clock, rising edge
- reset_n  in  1  reset, asynchronous, active-low
- clear  in  1  synchronous flush to empty; highest priority after reset
- in_data  in  DATA_W  stream element
- in_valid  in  1  in_data valid
- in_ready  out  1  high while in LOAD state (combinational from state)
- rd_req  in  1  request one column
- rd_mode  in  1  0 = rotate (replay), 1 = consume; sampled with rd_req
- rd_data  out  LANES*DATA_W  column output, lane i at bits [i*DATA_W +: DATA_W]
- rd_valid  out  1  one-cycle pulse, rd_data valid
- load_done  out  1  one-cycle pulse, buffers just became full
- full  out  1  level, high in FULL state
- overflow  out  1  sticky: in_valid seen while FULL

## Operation
- States: LOAD (accepting writes) and FULL (serving reads). Reset and clear enter LOAD with wr_cnt=0, rd_ptr=0.
- LOAD: each cycle with in_valid=1 accepts one element. Element k (0-based since empty) goes to lane k mod LANES, slot k div LANES. wr_cnt is $clog2(LANES*DEPTH) bits wide.
- Accepting element LANES*DEPTH-1 moves the block to FULL and pulses load_done. wr_cnt returns to 0.
- LOAD with rd_req: the request is ignored and no rd_valid is produced. If in_valid and rd_req are both high, the write is taken.
- FULL with in_valid: the data is dropped, overflow is set to 1 (sticky until clear or reset), and the state is unchanged.
- FULL with rd_req: rd_data lane i takes lane i slot rd_ptr, and rd_valid pulses. rd_ptr is $clog2(DEPTH) bits and advances with wrap from DEPTH-1 to 0.
- Rotate read (rd_mode=0): the block stays FULL after the wrap, so data is reusable indefinitely.
- Consume read (rd_mode=1) at rd_ptr=DEPTH-1: the block returns to LOAD (empty) and rd_ptr goes to 0. A consume read at any other rd_ptr only advances the pointer. Modes may be mixed freely.
- Storage contents are not cleared by clear or by consume. They are simply overwritten by the next load.
- rd_data holds its last value between reads.

## Timing
- Reset values: in_ready=1, rd_data=0, rd_valid=0, load_done=0, full=0, overflow=0. Storage resets to 0.
- Write: the element is captured on the clk edge where in_valid && in_ready.
- load_done and full both rise the cycle after the last element is accepted. in_ready falls at the same time.
- Read latency is 1 cycle: rd_req at edge n gives rd_valid and rd_data valid after edge n+1. Back-to-back rd_req every cycle gives one column per cycle.
- After a final consume read, in_ready=1 and full=0 the cycle after that request. A write in that next cycle is accepted.
- clear while rd_req is high: the read is suppressed, with no rd_valid.
- Reset asserted mid-load or mid-read: all state is aborted immediately, asynchronously, and the reset values apply.

## Structure
- Package lane_loader_pkg holds:
  - typedef enum logic {LOAD, FULL} ll_state_t
  - a function for the lane/slot index split
- Sub-module lane_buffer holds one lane: DEPTH×DATA_W register array with a write enable, write slot and read slot. It is instantiated LANES times via generate.
- lane_loader holds the FSM, wr_cnt, rd_ptr, the overflow flag and the output registers.

## Test plan
(defaults LANES=4, DEPTH=8, DATA_W=8)
- Load bytes 0x00..0x1F on consecutive cycles -> load_done pulses once, one cycle after byte 0x1F; full=1, in_ready=0. First rd_req -> rd_data=0x03020100 with rd_valid after 1 cycle.
- Rotate: 9 back-to-back rd_req with rd_mode=0 -> columns 0x03020100, 0x07060504 … 0x1F1E1D1C, then 0x03020100 again; full stays 1.
- Consume: 8 rd_req with rd_mode=1 -> after the 8th, full=0 and in_ready=1. Reload 0x20..0x3F -> first column reads 0x23222120.
- Overflow: in_valid with data 0xAA while FULL -> overflow=1 (sticky), all columns unchanged. clear -> overflow=0 and full=0.
- Simultaneous: in_valid and rd_req high during LOAD -> write accepted, rd_valid stays 0, wr_cnt advances.
- Reset mid-load after 10 bytes -> all outputs at reset values. A fresh 32-byte load then reads column 0 = 0x03020100 for input 0x00..0x1F.
